// File: rtl/nios_system_led_fader_if.sv
// Signal bundle between the LED PIO out_port and the LED fader stage.
// The PIO side uses the master modport; the fader uses the slave modport.
interface nios_system_led_fader_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8
);
  logic [NUM_LEDS-1:0]          led_req;
  logic                         fade_bypass;
  logic [NUM_LEDS-1:0]          led_out;
  logic                         busy;
  logic [NUM_LEDS*PWM_BITS-1:0] level_flat;

  modport master (
    output led_req, fade_bypass,
    input  led_out, busy, level_flat
  );

  modport slave (
    input  led_req, fade_bypass,
    output led_out, busy, level_flat
  );
endinterface

// File: rtl/nios_system_led_fader.sv
// Per-LED brightness fader: ramps each level toward on/off and drives the pins with PWM.
// Optional macro LED_FADER_GAMMA_EN squares the level for a perceptually linear fade.
module nios_system_led_fader #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_system_led_fader_if.slave bus
);
  localparam int DIV_BITS = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [DIV_BITS-1:0] DIV_LAST  = DIV_BITS'(STEP_DIV - 1);

  logic [DIV_BITS-1:0] div_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level      [NUM_LEDS];
  logic [PWM_BITS-1:0] level_next [NUM_LEDS];
  logic [PWM_BITS-1:0] target     [NUM_LEDS];
  logic [PWM_BITS-1:0] duty       [NUM_LEDS];
  logic [NUM_LEDS-1:0] differs;
  logic [NUM_LEDS-1:0] pwm_next;
  logic [NUM_LEDS-1:0] led_out_q;

  // The divider free-runs; request changes never restart it.
  assign step_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= step_tick ? '0 : div_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Targets are only 0 or LEVEL_MAX, so stepping toward them can never wrap.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      target[i]     = bus.led_req[i] ? LEVEL_MAX : '0;
      level_next[i] = level[i];
      differs[i]    = (level[i] != target[i]);
      if (bus.fade_bypass) begin
        level_next[i] = target[i];
      end else if (step_tick) begin
        if (level[i] < target[i]) begin
          level_next[i] = level[i] + 1'b1;
        end else if (level[i] > target[i]) begin
          level_next[i] = level[i] - 1'b1;
        end
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] square [NUM_LEDS];

  // Full scale stays solid on rather than dropping to (MAX*MAX)>>PWM_BITS.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      square[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
      if (level[i] == LEVEL_MAX) begin
        duty[i] = LEVEL_MAX;
      end else begin
        duty[i] = square[i][2*PWM_BITS-1:PWM_BITS];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      duty[i] = level[i];
    end
  end
`endif

  // Full duty is forced high so a fully-on LED has no one-count dark gap.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      pwm_next[i] = 1'b0;
      if (duty[i] == LEVEL_MAX) begin
        pwm_next[i] = 1'b1;
      end else if (duty[i] != '0) begin
        pwm_next[i] = (pwm_cnt < duty[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
      led_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level[i] <= level_next[i];
      end
      led_out_q <= pwm_next;
    end
  end

  assign bus.led_out = led_out_q;
  assign bus.busy    = ~reset & (|differs);

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_flat
    assign bus.level_flat[g*PWM_BITS +: PWM_BITS] = level[g];
  end
endmodule

// File: tb/tb_nios_system_led_fader.sv
// Self-checking bench for nios_system_led_fader: directed ramps, reversals and a bypass vector table.
module tb_nios_system_led_fader;
  localparam int NUM_LEDS  = 4;
  localparam int PWM_BITS  = 4;
  localparam int STEP_DIV  = 4;
  localparam int LEVEL_MAX = 15;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] exp_level;
    logic        exp_busy;
    logic [3:0]  exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  int   exp_lvl [NUM_LEDS];
  vec_t vecs [5];

  nios_system_led_fader_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) bus ();

  nios_system_led_fader #(
    .NUM_LEDS(NUM_LEDS),
    .PWM_BITS(PWM_BITS),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (k=%0d)", name, actual, expected, k);
    end
  endtask

  function automatic logic pwmBit(input int lvl, input int cnt);
    int d;
`ifdef LED_FADER_GAMMA_EN
    d = (lvl == LEVEL_MAX) ? LEVEL_MAX : ((lvl * lvl) >> PWM_BITS);
`else
    d = lvl;
`endif
    if (d == 0) return 1'b0;
    if (d == LEVEL_MAX) return 1'b1;
    return (cnt < d);
  endfunction

  function automatic logic [15:0] packLevels();
    logic [15:0] r;
    for (int i = 0; i < NUM_LEDS; i++) r[i*4 +: 4] = 4'(exp_lvl[i]);
    return r;
  endfunction

  task automatic applyStimulus(input logic [3:0] req);
    reset = 1'b1;
    bus.led_req = req;
    bus.fade_bypass = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_LEDS; i++) exp_lvl[i] = 0;
  endtask

  // Advance n clocks with fade_bypass low, tracking expected levels and PWM output.
  task automatic runAndCheck(input string tag, input int n);
    int prev [NUM_LEDS];
    logic [3:0] req;
    logic [3:0] exp_out;
    logic exp_busy;
    for (int c = 0; c < n; c++) begin
      req = bus.led_req;
      prev = exp_lvl;
      tick();
      k++;
      if (k % STEP_DIV == 0) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (req[i] && exp_lvl[i] < LEVEL_MAX) exp_lvl[i]++;
          else if (!req[i] && exp_lvl[i] > 0) exp_lvl[i]--;
        end
      end
      exp_busy = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        exp_out[i] = pwmBit(prev[i], (k - 1) % 16);
        if (exp_lvl[i] != (req[i] ? LEVEL_MAX : 0)) exp_busy = 1'b1;
      end
      checkOutput({tag, "_level"}, 32'(bus.level_flat), 32'(packLevels()));
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
      checkOutput({tag, "_led_out"}, 32'(bus.led_out), 32'(exp_out));
    end
  endtask

  initial begin
    vecs[0] = '{4'b1010, 16'hF0F0, 1'b0, 4'b1010};
    vecs[1] = '{4'b0101, 16'h0F0F, 1'b0, 4'b0101};
    vecs[2] = '{4'b1111, 16'hFFFF, 1'b0, 4'b1111};
    vecs[3] = '{4'b0000, 16'h0000, 1'b0, 4'b0000};
    vecs[4] = '{4'b1100, 16'hFF00, 1'b0, 4'b1100};

    // Reset held three cycles with all LEDs requested on
    bus.led_req = 4'hF;
    bus.fade_bypass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_led_out", 32'(bus.led_out), 32'h0);
      checkOutput("rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("rst_level", 32'(bus.level_flat), 32'h0);
    end
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_LEDS; i++) exp_lvl[i] = 0;
    runAndCheck("first", 3);
    checkOutput("first_pre_tick", 32'(bus.level_flat), 32'h0000);
    runAndCheck("first", 1);
    checkOutput("first_tick", 32'(bus.level_flat), 32'h1111);

    // Ramp LED0 up to full
    applyStimulus(4'b0001);
    runAndCheck("ramp", 59);
    checkOutput("ramp_at14_level", 32'(bus.level_flat), 32'h000E);
    checkOutput("ramp_at14_busy", 32'(bus.busy), 32'h1);
    runAndCheck("ramp", 1);
    checkOutput("ramp_at15_level", 32'(bus.level_flat), 32'h000F);
    checkOutput("ramp_at15_busy", 32'(bus.busy), 32'h0);
    runAndCheck("ramp_hold", 20);
    checkOutput("ramp_solid", 32'(bus.led_out), 32'h1);

    // PWM on LED1 through level 5 then back down
    applyStimulus(4'b0010);
    runAndCheck("pwm", 21);
    checkOutput("pwm_level5", 32'(bus.level_flat), 32'h0050);
    bus.led_req = 4'b0000;
    runAndCheck("pwm_down", 24);

    // Reversal of LED2 at level 9, away from a step tick
    applyStimulus(4'b0100);
    runAndCheck("rev", 37);
    checkOutput("rev_level9", 32'(bus.level_flat), 32'h0900);
    bus.led_req = 4'b0000;
    runAndCheck("rev", 3);
    checkOutput("rev_level8", 32'(bus.level_flat), 32'h0800);
    runAndCheck("rev_floor", 40);
    checkOutput("rev_no_wrap", 32'(bus.level_flat), 32'h0000);

    // Reversal landing in the same cycle as the step tick
    applyStimulus(4'b0100);
    runAndCheck("revc", 39);
    checkOutput("revc_level9", 32'(bus.level_flat), 32'h0900);
    bus.led_req = 4'b0000;
    runAndCheck("revc", 1);
    checkOutput("revc_level8", 32'(bus.level_flat), 32'h0800);

    // Bypass vectors: levels jump in one clock, outputs follow one clock later
    applyStimulus(4'b0000);
    for (int v = 0; v < 5; v++) begin
      bus.fade_bypass = 1'b1;
      bus.led_req = vecs[v].req;
      tick();
      checkOutput($sformatf("byp%0d_level", v), 32'(bus.level_flat), 32'(vecs[v].exp_level));
      checkOutput($sformatf("byp%0d_busy", v), 32'(bus.busy), 32'(vecs[v].exp_busy));
      tick();
      checkOutput($sformatf("byp%0d_led_out", v), 32'(bus.led_out), 32'(vecs[v].exp_out));
    end
    bus.fade_bypass = 1'b0;

    // Reset arriving mid-ramp at level 7
    applyStimulus(4'b1111);
    runAndCheck("mid", 29);
    checkOutput("mid_level7", 32'(bus.level_flat), 32'h7777);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_level", 32'(bus.level_flat), 32'h0000);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("mid_rst_led_out", 32'(bus.led_out), 32'h0);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < NUM_LEDS; i++) exp_lvl[i] = 0;
    runAndCheck("restart", 4);
    checkOutput("restart_level1", 32'(bus.level_flat), 32'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
